// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial adder controller: feeds one 4-bit slice per cycle to an external
// 4-bit adder, LSB first, and assembles the registered W-bit sum and final carry.
module nibble_serial_add_ctrl #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout,
  output logic [3:0]           add_x,
  output logic [3:0]           add_y,
  output logic                 add_z,
  input  logic [3:0]           add_s,
  input  logic                 add_c
);

  localparam int unsigned W    = 4 * NIBBLES;
  localparam int unsigned IdxW = $clog2(NIBBLES);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              cr_q, cr_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic [W-1:0]      sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              last_slice;

  assign last_slice = (idx_q == IdxW'(NIBBLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      cr_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cr_q    <= cr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cr_d    = cr_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          cr_d    = cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d[4*idx_q +: 4] = add_s;
        cr_d                = add_c;
        if (last_slice) begin
          cout_d  = add_c;
          // Explicit clear so non-power-of-two NIBBLES never leaves idx out of range.
          idx_d   = '0;
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decode straight from registered state, so reset clears them without a clock.
  assign busy  = (state_q == StRun);
  assign done  = (state_q == StDone);
  assign sum   = sum_q;
  assign cout  = cout_q;
  assign add_x = busy ? a_q[4*idx_q +: 4] : 4'h0;
  assign add_y = busy ? b_q[4*idx_q +: 4] : 4'h0;
  assign add_z = busy ? cr_q : 1'b0;

endmodule

// File: doc/nibble_serial_add_ctrl.md
NIBBLE_SERIAL_ADD_CTRL -- requirements
Module: nibble_serial_add_ctrl

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, number of 4-bit slices per operand; legal range 2..8; operand width W = 4*NIBBLES.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request a new addition; sampled only in IDLE.
REQ-005 SHALL have port a  input  W  operand A.
REQ-006 SHALL have port b  input  W  operand B.
REQ-007 SHALL have port cin  input  1  initial carry-in.
REQ-008 SHALL have port busy  output  1  high while slices are being processed.
REQ-009 SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-010 SHALL have port sum  output  W  registered result, held until next accepted start.
REQ-011 SHALL have port cout  output  1  registered final carry, held with sum.
REQ-012 SHALL have port add_x  output  4  X operand to the external 4-bit adder.
REQ-013 SHALL have port add_y  output  4  Y operand to the external 4-bit adder.
REQ-014 SHALL have port add_z  output  1  carry-in to the external 4-bit adder.
REQ-015 SHALL have port add_s  input  4  sum from the external 4-bit adder, combinational.
REQ-016 SHALL have port add_c  input  1  carry-out from the external 4-bit adder, combinational.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DONE with a slice index idx (width ceil(log2 NIBBLES)) and a carry register cr.
REQ-018 SHALL, in IDLE with start=1 at an edge, latch a, b into internal registers, set cr=cin, idx=0, clear sum and cout, and enter RUN.
REQ-019 SHALL, in IDLE with start=0, remain in IDLE.
REQ-020 SHALL, in RUN, drive add_x=a_reg[4*idx+3:4*idx], add_y=b_reg[same], add_z=cr; slices processed LSB first.
REQ-021 SHALL, at each RUN edge, write add_s into sum[4*idx+3:4*idx], load cr=add_c, and increment idx.
REQ-022 SHALL, at the RUN edge where idx=NIBBLES-1, also load cout=add_c and enter DONE.
REQ-023 SHALL, in DONE, assert done for exactly one cycle, then return to IDLE unconditionally; start during DONE ignored.
REQ-024 SHALL assert busy exactly in RUN; done exactly in DONE; never both.
REQ-025 SHALL drive add_x=0, add_y=0, add_z=0 outside RUN.
REQ-026 SHALL give latency: start sampled at edge E0, done high in the cycle after edge E0+NIBBLES.
REQ-027 SHALL ignore start, a, b, cin while in RUN or DONE; latched operands are unaffected by input changes.
REQ-028 SHALL produce {cout,sum} = a + b + cin, modulo 2^(W+1), for all operand values.
REQ-029 SHALL keep sum and cout stable from done until the next accepted start.
REQ-030 SHALL, with start held high continuously, accept a new operation on the first IDLE edge after DONE (period NIBBLES+2 cycles).

Reset
REQ-031 SHALL, on rst=1 at any time including mid-RUN, immediately force state IDLE, idx=0, cr=0, sum=0, cout=0, busy=0, done=0, add_x/add_y/add_z=0, without waiting for clk.
REQ-032 SHALL resume normal operation on the first rising clk edge after rst deasserts; no partial result survives.

Verification (NIBBLES=4, external port driven by a behavioural 4-bit adder)
REQ-033 SHALL verify a=0x1234, b=0x4321, cin=0, start one cycle -> add_x sequence 4,3,2,1; done 4 edges after start; sum=0x5555, cout=0.
REQ-034 SHALL verify a=0xFFFF, b=0x0000, cin=1 -> carry ripples through all slices; sum=0x0000, cout=1.
REQ-035 SHALL verify a=0xFFFF, b=0xFFFE, cin=0 -> sum=0xFFFD, cout=1; then a=0xADAD, b=0x8080, cin=1 -> sum=0x2E2E, cout=1.
REQ-036 SHALL verify start pulsed and a/b changed to 0x0000 during RUN -> result unchanged from operands latched at accepted start; busy stays high 4 cycles.
REQ-037 SHALL verify rst asserted asynchronously after 2nd RUN edge -> busy, sum, cout, add_* zero before next clk edge; subsequent start 0x0001+0x0001 -> sum=0x0002.
REQ-038 SHALL verify start held high for 3 operations -> done pulses every 6 cycles, each sum correct.
